// File: rtl/biriscv_alu_issue_wb.sv
// Issue/writeback wrapper around the 2-cycle pipelined integer ALU.
// Upstream it handshakes issued ops and stalls on RAW hazards and on missing
// writeback credit. Downstream it tracks destination tags alongside the ALU
// and buffers results in a fall-through skid FIFO, because the ALU cannot stall.
module biriscv_alu_issue_wb #(
   parameter int unsigned WB_FIFO_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        issue_valid_i,
   output logic        issue_ready_o,
   input  logic [3:0]  issue_op_i,
   input  logic [31:0] issue_a_i,
   input  logic [31:0] issue_b_i,
   input  logic [4:0]  issue_ra_idx_i,
   input  logic [4:0]  issue_rb_idx_i,
   input  logic        issue_ra_use_i,
   input  logic        issue_rb_use_i,
   input  logic [4:0]  issue_rd_idx_i,
   input  logic        flush_i,
   output logic        alu_valid_o,
   output logic [3:0]  alu_op_o,
   output logic [31:0] alu_a_o,
   output logic [31:0] alu_b_o,
   input  logic        alu_valid_i,
   input  logic [31:0] alu_p_i,
   output logic        wb_valid_o,
   input  logic        wb_ready_i,
   output logic [4:0]  wb_rd_idx_o,
   output logic [31:0] wb_value_o,
   output logic        err_o
);

   localparam int unsigned PTR_W = (WB_FIFO_DEPTH > 1) ? $clog2(WB_FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned OCC_W = CNT_W + 1;

   // Shadow tag pipeline (T1 -> T2) aligned with ALU latency
   logic             r_t1_valid;
   logic [4:0]       r_t1_rd;
   logic             r_t2_valid;
   logic [4:0]       r_t2_rd;

   // Writeback skid FIFO
   logic [4:0]               r_fifo_rd  [WB_FIFO_DEPTH];
   logic [31:0]              r_fifo_val [WB_FIFO_DEPTH];
   logic [WB_FIFO_DEPTH-1:0] r_fifo_vld;
   logic [PTR_W-1:0]         r_wr_ptr;
   logic [PTR_W-1:0]         r_rd_ptr;
   logic [CNT_W-1:0]         r_count;
   logic                     r_err;

   logic             w_empty;
   logic             w_full;
   logic             w_complete;
   logic             w_enq;
   logic             w_enq_ok;
   logic             w_overflow;
   logic             w_pop;
   logic             w_t2_err;
   logic             w_accept;
   logic [OCC_W-1:0] w_occ;
   logic             w_credit_ok;
   logic             w_hz_a;
   logic             w_hz_b;
   logic             w_hazard;
   logic [4:0]       w_head_rd;
   logic [31:0]      w_head_val;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_W'(WB_FIFO_DEPTH));
   assign w_complete = r_t2_valid && alu_valid_i;
   assign w_t2_err   = r_t2_valid && !alu_valid_i;

   // Fall-through: an empty FIFO presents the completing result directly
   assign w_head_rd  = w_empty ? r_t2_rd : r_fifo_rd[r_rd_ptr];
   assign w_head_val = w_empty ? alu_p_i : r_fifo_val[r_rd_ptr];

   assign wb_valid_o  = !rst_i && (!w_empty || w_complete);
   assign wb_rd_idx_o = wb_valid_o ? w_head_rd  : 5'd0;
   assign wb_value_o  = wb_valid_o ? w_head_val : 32'd0;

   assign w_pop      = wb_valid_o && wb_ready_i && !w_empty;
   assign w_enq      = w_complete && !(w_empty && wb_ready_i);
   assign w_overflow = w_enq && w_full;
   assign w_enq_ok   = w_enq && !w_full;

   // Credit ignores a same-cycle dequeue so the FIFO cannot overflow
   assign w_occ       = OCC_W'(r_count) + OCC_W'(r_t1_valid) + OCC_W'(r_t2_valid);
   assign w_credit_ok = (w_occ < OCC_W'(WB_FIFO_DEPTH));

   // RAW hazard: used nonzero source against any in-flight or buffered destination
   always_comb begin
      w_hz_a = 1'b0;
      w_hz_b = 1'b0;
      if (r_t1_valid && (r_t1_rd == issue_ra_idx_i)) w_hz_a = 1'b1;
      if (r_t1_valid && (r_t1_rd == issue_rb_idx_i)) w_hz_b = 1'b1;
      if (r_t2_valid && (r_t2_rd == issue_ra_idx_i)) w_hz_a = 1'b1;
      if (r_t2_valid && (r_t2_rd == issue_rb_idx_i)) w_hz_b = 1'b1;
      for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
         if (r_fifo_vld[i] && (r_fifo_rd[i] == issue_ra_idx_i)) w_hz_a = 1'b1;
         if (r_fifo_vld[i] && (r_fifo_rd[i] == issue_rb_idx_i)) w_hz_b = 1'b1;
      end
      w_hazard = (issue_ra_use_i && (issue_ra_idx_i != 5'd0) && w_hz_a) ||
                 (issue_rb_use_i && (issue_rb_idx_i != 5'd0) && w_hz_b);
   end

   assign issue_ready_o = !rst_i && !flush_i && w_credit_ok && !w_hazard;
   assign w_accept      = issue_valid_i && issue_ready_o;

   assign alu_valid_o = w_accept;
   assign alu_op_o    = rst_i ? 4'd0  : issue_op_i;
   assign alu_a_o     = rst_i ? 32'd0 : issue_a_i;
   assign alu_b_o     = rst_i ? 32'd0 : issue_b_i;
   assign err_o       = r_err && !rst_i;

   // Tag pipeline, FIFO control and sticky error
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_t1_valid <= 1'b0;
         r_t1_rd    <= 5'd0;
         r_t2_valid <= 1'b0;
         r_t2_rd    <= 5'd0;
         r_fifo_vld <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_err      <= 1'b0;
      end else begin
         r_t1_valid <= w_accept && (issue_rd_idx_i != 5'd0);
         r_t1_rd    <= issue_rd_idx_i;
         r_t2_valid <= r_t1_valid && !flush_i;
         r_t2_rd    <= r_t1_rd;
         if (w_pop) begin
            r_fifo_vld[r_rd_ptr] <= 1'b0;
            r_rd_ptr             <= r_rd_ptr + PTR_W'(1);
         end
         if (w_enq_ok) begin
            r_fifo_vld[r_wr_ptr] <= 1'b1;
            r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_enq_ok) - CNT_W'(w_pop);
         if (w_t2_err || w_overflow) r_err <= 1'b1;
      end
   end

   // FIFO payload storage (validity is tracked separately)
   always_ff @(posedge clk_i) begin
      if (w_enq_ok) begin
         r_fifo_rd[r_wr_ptr]  <= r_t2_rd;
         r_fifo_val[r_wr_ptr] <= alu_p_i;
      end
   end

endmodule

// File: tb/tb_biriscv_alu_issue_wb.sv
// Scoreboard bench for biriscv_alu_issue_wb with a behavioural 2-cycle ALU.
module tb_biriscv_alu_issue_wb;

   localparam logic [3:0] ALU_ADD = 4'd4;
   localparam logic [3:0] ALU_AND = 4'd7;
   localparam logic [3:0] ALU_OR  = 4'd8;
   localparam logic [3:0] ALU_XOR = 4'd9;
   localparam logic [3:0] ALU_SUB = 4'd12;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        issue_valid_i;
   logic        issue_ready_o;
   logic [3:0]  issue_op_i;
   logic [31:0] issue_a_i;
   logic [31:0] issue_b_i;
   logic [4:0]  issue_ra_idx_i;
   logic [4:0]  issue_rb_idx_i;
   logic        issue_ra_use_i;
   logic        issue_rb_use_i;
   logic [4:0]  issue_rd_idx_i;
   logic        flush_i;
   logic        alu_valid_o;
   logic [3:0]  alu_op_o;
   logic [31:0] alu_a_o;
   logic [31:0] alu_b_o;
   logic        alu_valid_i;
   logic [31:0] alu_p_i;
   logic        wb_valid_o;
   logic        wb_ready_i;
   logic [4:0]  wb_rd_idx_o;
   logic [31:0] wb_value_o;
   logic        err_o;

   int total = 0;
   int bad   = 0;
   logic [36:0] sb_q[$];

   always #5 clk_i = ~clk_i;

   biriscv_alu_issue_wb #(.WB_FIFO_DEPTH(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_op_i(issue_op_i), .issue_a_i(issue_a_i), .issue_b_i(issue_b_i),
      .issue_ra_idx_i(issue_ra_idx_i), .issue_rb_idx_i(issue_rb_idx_i),
      .issue_ra_use_i(issue_ra_use_i), .issue_rb_use_i(issue_rb_use_i),
      .issue_rd_idx_i(issue_rd_idx_i), .flush_i(flush_i),
      .alu_valid_o(alu_valid_o), .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
      .alu_valid_i(alu_valid_i), .alu_p_i(alu_p_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
      .wb_rd_idx_o(wb_rd_idx_o), .wb_value_o(wb_value_o), .err_o(err_o)
   );

   // Behavioural 2-cycle ALU; reset only at time zero so stale results survive a DUT reset
   logic        alu_rst;
   logic        alu_drop;
   logic        s1_v, s2_v;
   logic [3:0]  s1_op;
   logic [31:0] s1_a, s1_b, s2_p;

   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   always_ff @(posedge clk_i) begin
      if (alu_rst) begin
         s1_v <= 1'b0;
         s2_v <= 1'b0;
      end else begin
         s1_v <= alu_valid_o;
         s2_v <= s1_v;
      end
      s1_op <= alu_op_o;
      s1_a  <= alu_a_o;
      s1_b  <= alu_b_o;
      s2_p  <= alu_fn(s1_op, s1_a, s1_b);
   end

   assign alu_valid_i = s2_v && !alu_drop;
   assign alu_p_i     = s2_p;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   // Monitor: every writeback handshake is compared against the scoreboard head
   always @(negedge clk_i) begin
      if (!rst_i && wb_valid_o && wb_ready_i) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wb_unexpected got rd=%0d val=%0h want none", wb_rd_idx_o, wb_value_o);
         end else begin
            logic [36:0] e;
            e = sb_q.pop_front();
            chk("wb_rd", 32'(wb_rd_idx_o), 32'(e[36:32]));
            chk("wb_value", wb_value_o, e[31:0]);
         end
      end
   end

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] ra, input logic rau, input logic [4:0] rb,
                        input logic rbu, input logic [4:0] rd);
      issue_valid_i  = 1'b1;
      issue_op_i     = op;
      issue_a_i      = a;
      issue_b_i      = b;
      issue_ra_idx_i = ra;
      issue_ra_use_i = rau;
      issue_rb_idx_i = rb;
      issue_rb_use_i = rbu;
      issue_rd_idx_i = rd;
   endtask

   // Offer an op until accepted; returns the number of stalled cycles
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] ra, input logic rau, input logic [4:0] rb,
                        input logic rbu, input logic [4:0] rd, input logic [31:0] exp,
                        input logic push, output int stalls);
      bit done;
      done   = 1'b0;
      stalls = 0;
      drive(op, a, b, ra, rau, rb, rbu, rd);
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk_i);
         if (issue_ready_o) begin
            if (push && rd != 5'd0) sb_q.push_back({rd, exp});
            done = 1'b1;
         end else begin
            stalls++;
         end
         @(posedge clk_i); #1;
      end
      issue_valid_i = 1'b0;
      if (!done) chk("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, sum, rdy;
      logic [31:0] exp_credit [6];
      exp_credit[0] = 32'd11; exp_credit[1] = 32'd22; exp_credit[2] = 32'd33;
      exp_credit[3] = 32'd44; exp_credit[4] = 32'd55; exp_credit[5] = 32'd66;

      // Reset: outputs all zero even with an op offered
      rst_i = 1'b1; alu_rst = 1'b1; alu_drop = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b1;
      drive(ALU_ADD, 32'd1, 32'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1);
      @(posedge clk_i); #1;
      alu_rst = 1'b0;
      @(negedge clk_i);
      chk("rst_issue_ready", 32'(issue_ready_o), 32'd0);
      chk("rst_alu_valid", 32'(alu_valid_o), 32'd0);
      chk("rst_alu_a", alu_a_o, 32'd0);
      chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      issue_valid_i = 1'b0;
      idle(2);

      // Basic ADD 5+7 -> rd3 = 12 at N+2
      drive(ALU_ADD, 32'd5, 32'd7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3);
      @(negedge clk_i);
      chk("add_ready", 32'(issue_ready_o), 32'd1);
      chk("add_alu_valid", 32'(alu_valid_o), 32'd1);
      chk("add_alu_op", 32'(alu_op_o), 32'(ALU_ADD));
      chk("add_alu_a", alu_a_o, 32'd5);
      chk("add_alu_b", alu_b_o, 32'd7);
      sb_q.push_back({5'd3, 32'd12});
      @(posedge clk_i); #1;
      issue_valid_i = 1'b0;
      @(negedge clk_i);
      chk("add_wb_n1", 32'(wb_valid_o), 32'd0);
      @(negedge clk_i);
      chk("add_wb_n2", 32'(wb_valid_o), 32'd1);
      chk("add_err", 32'(err_o), 32'd0);
      idle(4);

      // RAW hazard on ra=3: stalls through T1 and T2, clears after the wb handshake
      issue(ALU_ADD, 32'd1, 32'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 32'd3, 1'b1, st);
      issue(ALU_ADD, 32'd3, 32'd4, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 32'd7, 1'b1, st);
      chk("hazard_stalls", 32'(st), 32'd2);
      issue(ALU_AND, 32'hFF, 32'h0F, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 32'h0F, 1'b1, st);
      issue(ALU_OR, 32'd1, 32'd2, 5'd3, 1'b0, 5'd3, 1'b0, 5'd5, 32'd3, 1'b1, st);
      chk("no_use_stalls", 32'(st), 32'd0);
      idle(6);

      // Credit: wb blocked, exactly 4 accepted, then ready stays low
      wb_ready_i = 1'b0;
      sum = 0;
      for (int k = 1; k <= 4; k++) begin
         issue(ALU_ADD, 32'(k * 10), 32'(k), 5'd0, 1'b0, 5'd0, 1'b0, 5'(k), exp_credit[k-1], 1'b1, st);
         sum += st;
      end
      chk("credit_first4_stalls", 32'(sum), 32'd0);
      drive(ALU_ADD, 32'd50, 32'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5);
      rdy = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         if (issue_ready_o) rdy++;
      end
      chk("credit_blocked", 32'(rdy), 32'd0);
      @(posedge clk_i); #1;
      wb_ready_i = 1'b1;
      issue(ALU_ADD, 32'd50, 32'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, exp_credit[4], 1'b1, st);
      issue(ALU_ADD, 32'd60, 32'd6, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, exp_credit[5], 1'b1, st);
      idle(8);

      // Flush in the cycle rd1 completes: rd1 written, rd2/rd3 killed
      issue(ALU_XOR, 32'hF0, 32'hFF, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 32'h0F, 1'b1, st);
      issue(ALU_ADD, 32'd2, 32'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 32'd4, 1'b0, st);
      drive(ALU_ADD, 32'd3, 32'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3);
      flush_i = 1'b1;
      @(negedge clk_i);
      chk("flush_ready", 32'(issue_ready_o), 32'd0);
      chk("flush_alu_valid", 32'(alu_valid_o), 32'd0);
      chk("flush_wb_valid", 32'(wb_valid_o), 32'd1);
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      issue_valid_i = 1'b0;
      issue(ALU_OR, 32'h10, 32'h01, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 32'h11, 1'b1, st);
      chk("post_flush_stalls", 32'(st), 32'd0);
      idle(6);

      // rd=0: no writeback, no hazard on source 0
      issue(ALU_ADD, 32'd9, 32'd9, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd18, 1'b0, st);
      issue(ALU_SUB, 32'd10, 32'd3, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 32'd7, 1'b1, st);
      chk("rd0_src_stalls", 32'(st), 32'd0);
      @(negedge clk_i);
      chk("rd0_no_wb", 32'(wb_valid_o), 32'd0);
      @(posedge clk_i); #1;
      idle(5);

      // rd=0 does not consume credit: 4 more ops accepted with wb blocked
      wb_ready_i = 1'b0;
      issue(ALU_ADD, 32'd9, 32'd9, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd18, 1'b0, st);
      sum = 0;
      for (int k = 1; k <= 4; k++) begin
         issue(ALU_ADD, 32'(k * 100), 32'(k), 5'd0, 1'b0, 5'd0, 1'b0, 5'(7 + k), 32'(k * 101), 1'b1, st);
         sum += st;
      end
      chk("rd0_credit_stalls", 32'(sum), 32'd0);
      wb_ready_i = 1'b1;
      idle(8);

      // Missing ALU valid while T2 valid: sticky error
      alu_drop = 1'b1;
      issue(ALU_ADD, 32'd1, 32'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 32'd2, 1'b0, st);
      @(negedge clk_i);
      chk("err_n1", 32'(err_o), 32'd0);
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("err_n2", 32'(err_o), 32'd0);
      chk("err_n2_wb", 32'(wb_valid_o), 32'd0);
      @(posedge clk_i); #1;
      alu_drop = 1'b0;
      @(negedge clk_i);
      chk("err_set", 32'(err_o), 32'd1);
      idle(4);
      @(negedge clk_i);
      chk("err_sticky", 32'(err_o), 32'd1);
      @(posedge clk_i); #1;

      // Reset mid-operation: stale ALU result ignored, error cleared
      issue(ALU_ADD, 32'd6, 32'd6, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 32'd12, 1'b0, st);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("midrst_ready", 32'(issue_ready_o), 32'd0);
      chk("midrst_err", 32'(err_o), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("stale_alu_valid_seen", 32'(alu_valid_i), 32'd1);
      chk("stale_no_wb", 32'(wb_valid_o), 32'd0);
      chk("stale_no_err", 32'(err_o), 32'd0);
      chk("post_rst_ready", 32'(issue_ready_o), 32'd1);
      @(posedge clk_i); #1;
      idle(3);
      chk("final_err", 32'(err_o), 32'd0);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/biriscv_alu_issue_wb.md
Name: biriscv_alu_issue_wb

Overview:
- Wraps the 2-cycle pipelined integer ALU on both sides.
- Upstream: accepts issued ALU ops through a valid/ready handshake, drives the ALU inputs, and stalls on RAW hazards against in-flight destinations.
- Downstream: runs a destination-tag shadow pipeline aligned with the ALU's 2-cycle latency, then presents results to the register-file writeback port through a fall-through skid FIFO, because the ALU cannot be stalled.

Parameters:
- WB_FIFO_DEPTH, 4, writeback skid FIFO entries (power of 2, >=2).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- issue_valid_i  in  1  op offered.
- issue_ready_o  out  1  op accepted when valid&&ready.
- issue_op_i  in  4  ALU opcode (ALU_* encoding).
- issue_a_i  in  32  operand A.
- issue_b_i  in  32  operand B.
- issue_ra_idx_i  in  5  source A register index.
- issue_rb_idx_i  in  5  source B register index.
- issue_ra_use_i  in  1  source A is a register read.
- issue_rb_use_i  in  1  source B is a register read.
- issue_rd_idx_i  in  5  destination register; 0 = no writeback.
- flush_i  in  1  kill all ops not yet written to the FIFO.
- alu_valid_o  out  1  ALU valid_i.
- alu_op_o  out  4  ALU op.
- alu_a_o  out  32  ALU operand A.
- alu_b_o  out  32  ALU operand B.
- alu_valid_i  in  1  ALU valid_o.
- alu_p_i  in  32  ALU result.
- wb_valid_o  out  1  writeback offered.
- wb_ready_i  in  1  regfile accepts.
- wb_rd_idx_o  out  5  writeback register.
- wb_value_o  out  32  writeback data.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset: while rst_i is high, all outputs are 0, including issue_ready_o. After reset, tags are invalid, the FIFO is empty, and err_o=0.
- Issue pass-through (combinational):
  - alu_valid_o = issue_valid_i && issue_ready_o.
  - alu_op/a/b_o = issue inputs.
  - When alu_valid_o=0, alu_op/a/b_o are don't-care.
- Shadow tags:
  - T1 captures {valid, rd} on accept.
  - T2 <= T1 each cycle.
  - An op accepted in cycle N is in T2 at N+2, aligned with alu_valid_i.
  - If rd==0, the tag valid bit is cleared: the op executes, but its result is discarded.
- Completion: when T2 is valid and alu_valid_i=1, the result {T2.rd, alu_p_i} completes.
  - If T2 is valid and alu_valid_i=0, set err_o.
  - If alu_valid_i=1 and T2 is invalid, ignore the result; no error.
- Writeback FIFO (fall-through):
  - Empty FIFO and a completing result: wb_valid_o=1 in the same cycle (N+2). If wb_ready_i=1, the result is consumed. Otherwise it is enqueued.
  - Non-empty FIFO: the head is presented, and a completing result is enqueued at the tail. Order is strictly preserved.
  - Dequeue on wb_valid_o && wb_ready_i.
- Credit: let occ = fifo_count + T1.valid + T2.valid. issue_ready_o requires occ < WB_FIFO_DEPTH.
  - This check deliberately ignores a same-cycle dequeue, so the FIFO can never overflow.
  - If an enqueue hits a full FIFO regardless, set err_o and drop the result.
- Hazard: issue_ready_o=0 if any used source with index !=0 matches rd of a valid T1, a valid T2, or any valid FIFO entry (this includes the fall-through result being offered in the current cycle).
  - The stall clears in the cycle after the matching wb handshake.
  - rd==0 never hazards.
- issue_ready_o = !rst_i && !flush_i && credit_ok && !hazard. It must not depend on issue_valid_i.
- Flush:
  - In the flush cycle, issue_ready_o=0 and alu_valid_o=0.
  - T1 and T2 valid bits are cleared at the next edge.
  - The ALU result of a killed op arrives with T2 invalid and is ignored.
  - A result completing in the flush cycle itself (T2 valid) is still written; flush kills only ops whose completion cycle is strictly later.
  - FIFO contents are retained.
- Reset mid-operation: tags and FIFO are cleared synchronously. A stale alu_valid_i is ignored after reset.
- Back-to-back issue at 1 op/cycle with no hazards and wb_ready_i=1 gives 1 writeback/cycle at 2-cycle latency.

Test Plan:
- Reset, then issue ADD a=5 b=7 rd=3 at cycle N with wb_ready=1 -> alu_valid_o=1 at N; wb_valid_o=1, rd=3, value=12 at N+2; err_o=0.
- Issue rd=3, then next cycle an op with ra=3 used -> issue_ready_o=0 until the cycle after the rd=3 wb handshake; a second op with ra=3 and ra_use=0 is not stalled.
- wb_ready=0 held; issue 6 independent ops (rd=1..6), DEPTH=4 -> exactly 4 accepted, then issue_ready_o=0; release ready -> wb order rd=1,2,3,4; issue resumes.
- Issue ops rd=1,2,3 on consecutive cycles, flush_i in the cycle rd=1 completes -> only rd=1 written back; rd=2 and rd=3 are never written; the next issue after flush is accepted.
- Op with rd=0 -> no wb_valid_o; it causes no hazard for ra=0; occ is unaffected.
- Hold T2 valid but force alu_valid_i=0 -> err_o=1 at the next cycle and stays 1 until rst_i.
